phivers_link_rx_buffer: RTL and testbench
=========================================

// Module: phivers_link_rx_buffer
// PURPOSE
// - Receiving end of the credit-based Phivers link: sits at a router input port, behind the link stage.
// - Accepts words on the rx/cr_rx/eop_rx/data_rx side and stores them in a circular FIFO.
// - Returns credit only while space remains, and forwards words on a credit-based tx side.
// - Tracks the number of complete packets held and flags senders that ignore credit.
// PARAMETERS
// - ADDRESS     16'b0  router address, carried for reporting/debug only
// - PORT        ""     port name string, carried for reporting/debug only
// - DEPTH       8      FIFO entries; power of two, >= 2
// - WDOG_LIMIT  1024   stall-watchdog threshold in cycles (used only with PHIVERS_LINK_WDOG_EN)
// PORTS
// - clk_i          in   1                     clock, all state on rising edge
// - rst_i          in   1                     reset, asynchronous, active-high
// - rx_i           in   1                     upstream word valid
// - cr_rx_o        out  1                     credit to upstream: 1 = a word may be written this cycle
// - eop_rx_i       in   1                     upstream word is last of packet
// - data_rx_i      in   32                    upstream word
// - tx_o           out  1                     downstream word valid (FIFO not empty)
// - cr_tx_i        in   1                     downstream credit
// - eop_tx_o       out  1                     head word is last of packet
// - data_tx_o      out  32                    head word
// - occupancy_o    out  $clog2(DEPTH)+1       words currently stored
// - pkt_cnt_o      out  $clog2(DEPTH)+1       complete packets (eop words) currently stored
// - ovf_o          out  1                     sticky: rx_i seen while cr_rx_o = 0
// - stall_o        out  1                     watchdog stall flag (0 without PHIVERS_LINK_WDOG_EN)
// BEHAVIOUR
// - Reset (async assert, sync release): pointers = 0, occupancy = 0, pkt_cnt = 0, ovf = 0, stall = 0.
//   Outputs at reset: cr_rx_o = 1, tx_o = 0, eop_tx_o = 0, data_tx_o = 0.
//   Storage contents need not be reset; data_tx_o/eop_tx_o are gated to 0 while empty.
// - Write: rx_i & cr_rx_o writes {eop_rx_i, data_rx_i} at wr_ptr, then wr_ptr++ (wraps mod DEPTH).
// - cr_rx_o = (occupancy != DEPTH), decoded from registered count; no combinational path from rx_i.
// - Read: tx_o = (occupancy != 0). tx_o & cr_tx_i pops the head, then rd_ptr++ (wraps mod DEPTH).
// - First-word-fall-through: a word written at edge N appears on tx_o/data_tx_o after edge N (latency 1 cycle).
// - Simultaneous push and pop (non-empty, not full): occupancy unchanged, both pointers advance.
// - Full: cr_rx_o = 0. A same-cycle pop frees space, but cr_rx_o only rises the next cycle.
// - Empty: no pop is possible. A same-cycle push makes tx_o = 1 the next cycle.
// - pkt_cnt: +1 on push with eop, -1 on pop with eop; both together leaves it unchanged.
// - Overflow: rx_i = 1 while cr_rx_o = 0 drops the word (no pointer or count change) and sets ovf_o until reset.
// - Width: occupancy/pkt_cnt are $clog2(DEPTH)+1 bits, so DEPTH is representable; pointers are $clog2(DEPTH) bits.
// - No state machine beyond the FIFO counters; reset mid-packet discards all buffered words.
// CONFIGURATION
// - PHIVERS_LINK_WDOG_EN defined:
//   - stall counter increments each cycle tx_o & !cr_tx_i (head blocked by missing downstream credit).
//   - Counter clears on any pop or when empty, and saturates at WDOG_LIMIT.
//   - stall_o = 1 when count == WDOG_LIMIT, held until the next pop or reset (diagnoses credit withholding).
// - PHIVERS_LINK_WDOG_EN undefined: no counter logic; stall_o tied 0.
// TESTING
// - Reset, then single word D=32'hCAFE0001 with eop -> tx_o = 1 the next cycle, data_tx_o = CAFE0001,
//   eop_tx_o = 1, pkt_cnt_o = 1; pop -> occupancy_o = 0, pkt_cnt_o = 0.
// - DEPTH = 8, cr_tx_i = 0, push 8 words -> cr_rx_o = 0 after 8th, occupancy_o = 8;
//   drive rx_i once more -> ovf_o = 1, occupancy_o stays 8.
// - Full FIFO, push and pop attempted same cycle -> pop only, occupancy_o = 7, cr_rx_o = 1 the next cycle.
// - Continuous stream of 20 words, cr_tx_i = 1 -> output order identical across pointer wrap, occupancy_o <= 1.
// - Assert rst_i mid-packet with 5 words stored -> immediately tx_o = 0, cr_rx_o = 1, counts 0, ovf_o = 0.
// - PHIVERS_LINK_WDOG_EN, WDOG_LIMIT = 16: one word held, cr_tx_i = 0 for 16 cycles -> stall_o = 1;
//   cr_tx_i = 1 for one cycle -> stall_o = 0. Macro undefined -> stall_o = 0 throughout.

Source files
------------

// File: rtl/phivers_link_rx_buffer.sv
// Phivers link receive buffer: credit-based circular FIFO with packet count.
// Optional stall watchdog enabled by defining PHIVERS_LINK_WDOG_EN.
module phivers_link_rx_buffer #(
  parameter logic [15:0] ADDRESS    = 16'b0,
  parameter              PORT       = "",
  parameter int          DEPTH      = 8,
  parameter int          WDOG_LIMIT = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       rx_i,
  output logic                       cr_rx_o,
  input  logic                       eop_rx_i,
  input  logic [31:0]                data_rx_i,
  output logic                       tx_o,
  input  logic                       cr_tx_i,
  output logic                       eop_tx_o,
  output logic [31:0]                data_tx_o,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic [$clog2(DEPTH):0]     pkt_cnt_o,
  output logic                       ovf_o,
  output logic                       stall_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] L_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] L_ONE  = CW'(1);
  localparam logic [AW-1:0] L_PONE = AW'(1);

  // ADDRESS/PORT only identify the instance when debugging
  if (ADDRESS == 16'hFFFF && PORT == "" && WDOG_LIMIT < 0) begin : g_debug_tag
  end

  logic [32:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_occ;
  logic [CW-1:0] r_pkt;
  logic          r_ovf;

  logic [32:0]   w_head;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_pkt_in;
  logic          w_pkt_out;

  assign w_head    = r_mem[r_rd_ptr];
  assign w_empty   = (r_occ == '0);
  assign w_full    = (r_occ == L_FULL);
  assign w_push    = rx_i & ~w_full;
  assign w_pop     = ~w_empty & cr_tx_i;
  assign w_pkt_in  = w_push & eop_rx_i;
  assign w_pkt_out = w_pop & w_head[32];

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= {eop_rx_i, data_rx_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_pkt    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + L_PONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + L_PONE;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + L_ONE;
        2'b01:   r_occ <= r_occ - L_ONE;
        default: r_occ <= r_occ;
      endcase
      case ({w_pkt_in, w_pkt_out})
        2'b10:   r_pkt <= r_pkt + L_ONE;
        2'b01:   r_pkt <= r_pkt - L_ONE;
        default: r_pkt <= r_pkt;
      endcase
      if (rx_i & w_full) r_ovf <= 1'b1;
    end
  end

  assign cr_rx_o     = ~w_full;
  assign tx_o        = ~w_empty;
  assign eop_tx_o    = ~w_empty & w_head[32];
  assign data_tx_o   = w_empty ? 32'h0 : w_head[31:0];
  assign occupancy_o = r_occ;
  assign pkt_cnt_o   = r_pkt;
  assign ovf_o       = r_ovf;

`ifdef PHIVERS_LINK_WDOG_EN
  localparam int WW = $clog2(WDOG_LIMIT + 1);
  localparam logic [WW-1:0] L_LIM  = WW'(WDOG_LIMIT);
  localparam logic [WW-1:0] L_WONE = WW'(1);

  logic [WW-1:0] r_wdog;

  // Non-empty without a pop means the head is waiting on downstream credit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wdog <= '0;
    end else if (w_pop | w_empty) begin
      r_wdog <= '0;
    end else if (r_wdog != L_LIM) begin
      r_wdog <= r_wdog + L_WONE;
    end
  end

  assign stall_o = (r_wdog == L_LIM);
`else
  assign stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_phivers_link_rx_buffer.sv
// Scoreboard bench for phivers_link_rx_buffer (DEPTH 8, WDOG_LIMIT 16).
module tb_phivers_link_rx_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        cr_rx;
  logic        eop_rx;
  logic [31:0] data_rx;
  logic        tx;
  logic        cr_tx;
  logic        eop_tx;
  logic [31:0] data_tx;
  logic [3:0]  occ;
  logic [3:0]  pkt;
  logic        ovf;
  logic        stall;

  int checks = 0;
  int errors = 0;
  logic [32:0] sb[$];

  always #5 clk = ~clk;

  phivers_link_rx_buffer #(
    .ADDRESS(16'h0012), .PORT("EAST"), .DEPTH(8), .WDOG_LIMIT(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx), .cr_rx_o(cr_rx),
    .eop_rx_i(eop_rx), .data_rx_i(data_rx), .tx_o(tx),
    .cr_tx_i(cr_tx), .eop_tx_o(eop_tx), .data_tx_o(data_tx),
    .occupancy_o(occ), .pkt_cnt_o(pkt), .ovf_o(ovf), .stall_o(stall)
  );

  task automatic chk(input string name, input logic [32:0] act,
                     input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Word is expected downstream only when the bench knows it fits
  task automatic put(input logic [31:0] d, input logic e, input bit acc);
    rx = 1'b1;
    data_rx = d;
    eop_rx = e;
    if (acc) sb.push_back({e, d});
  endtask

  always @(negedge clk) begin
    if (!rst && tx && cr_tx) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 33'(sb.size()), 33'd1);
      end else begin
        chk("pop_word", {eop_tx, data_tx}, sb.pop_front());
      end
    end
`ifndef PHIVERS_LINK_WDOG_EN
    chk("stall_tied0", 33'(stall), 33'd0);
`endif
  end

  initial begin
    rst = 1'b1; rx = 1'b0; eop_rx = 1'b0; data_rx = '0; cr_tx = 1'b0;
    step(); step();
    chk("rst_cr_rx", 33'(cr_rx), 33'd1);
    chk("rst_tx", 33'(tx), 33'd0);
    chk("rst_eop_tx", 33'(eop_tx), 33'd0);
    chk("rst_data_tx", 33'(data_tx), 33'd0);
    chk("rst_occ", 33'(occ), 33'd0);
    chk("rst_pkt", 33'(pkt), 33'd0);
    chk("rst_ovf", 33'(ovf), 33'd0);
    rst = 1'b0;
    step();

    // single word with eop
    put(32'hCAFE0001, 1'b1, 1'b1);
    step();
    rx = 1'b0;
    chk("t1_tx", 33'(tx), 33'd1);
    chk("t1_data", 33'(data_tx), 33'h0CAFE0001);
    chk("t1_eop", 33'(eop_tx), 33'd1);
    chk("t1_pkt", 33'(pkt), 33'd1);
    cr_tx = 1'b1;
    step();
    cr_tx = 1'b0;
    chk("t1_occ0", 33'(occ), 33'd0);
    chk("t1_pkt0", 33'(pkt), 33'd0);
    chk("t1_tx0", 33'(tx), 33'd0);

    // fill to DEPTH, eop on words 4 and 8
    for (int i = 1; i <= 8; i++) begin
      put(32'hA000_0000 + 32'(i), (i % 4) == 0, 1'b1);
      step();
    end
    rx = 1'b0;
    chk("t2_cr_rx", 33'(cr_rx), 33'd0);
    chk("t2_occ8", 33'(occ), 33'd8);
    chk("t2_pkt2", 33'(pkt), 33'd2);
    chk("t2_ovf0", 33'(ovf), 33'd0);
    put(32'hDEAD_BEEF, 1'b1, 1'b0);
    step();
    rx = 1'b0;
    chk("t2_ovf1", 33'(ovf), 33'd1);
    chk("t2_occ_hold", 33'(occ), 33'd8);
    chk("t2_pkt_hold", 33'(pkt), 33'd2);

    // full: push and pop together, only the pop happens
    put(32'hBAD0_0001, 1'b0, 1'b0);
    cr_tx = 1'b1;
    chk("t3_cr_rx_low", 33'(cr_rx), 33'd0);
    step();
    rx = 1'b0;
    cr_tx = 1'b0;
    chk("t3_occ7", 33'(occ), 33'd7);
    chk("t3_cr_rx_up", 33'(cr_rx), 33'd1);
    chk("t3_pkt2", 33'(pkt), 33'd2);
    cr_tx = 1'b1;
    for (int i = 0; i < 7; i++) step();
    cr_tx = 1'b0;
    chk("t3_occ0", 33'(occ), 33'd0);
    chk("t3_pkt0", 33'(pkt), 33'd0);

    // 20-word stream across pointer wrap
    cr_tx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      put(32'h5000_0000 + 32'(i * 3), (i % 5) == 4, 1'b1);
      step();
      chk("t4_occ_le1", 33'(occ <= 4'd1), 33'd1);
    end
    rx = 1'b0;
    step();
    cr_tx = 1'b0;
    chk("t4_occ0", 33'(occ), 33'd0);
    chk("t4_pkt0", 33'(pkt), 33'd0);

    // reset mid-packet with 5 words stored
    for (int i = 0; i < 5; i++) begin
      put(32'h7700_0000 + 32'(i), 1'b0, 1'b0);
      step();
    end
    rx = 1'b0;
    chk("t5_occ5", 33'(occ), 33'd5);
    rst = 1'b1;
    #1;
    chk("t5_tx", 33'(tx), 33'd0);
    chk("t5_cr_rx", 33'(cr_rx), 33'd1);
    chk("t5_occ", 33'(occ), 33'd0);
    chk("t5_pkt", 33'(pkt), 33'd0);
    chk("t5_ovf", 33'(ovf), 33'd0);
    step();
    rst = 1'b0;
    step();

`ifdef PHIVERS_LINK_WDOG_EN
    put(32'h0BAD_F00D, 1'b1, 1'b1);
    step();
    rx = 1'b0;
    for (int i = 1; i < 16; i++) step();
    chk("t6_stall_pre", 33'(stall), 33'd0);
    step();
    chk("t6_stall_set", 33'(stall), 33'd1);
    step();
    chk("t6_stall_hold", 33'(stall), 33'd1);
    cr_tx = 1'b1;
    step();
    cr_tx = 1'b0;
    chk("t6_stall_clr", 33'(stall), 33'd0);
`endif

    step();
    chk("sb_drained", 33'(sb.size()), 33'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
